// File: rtl/pico_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pico_pkg
// Brief   : Opcodes, ALU codes, sequencer states and control bundle for the
//           picoMIPS multi-cycle control sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package pico_pkg;

  localparam logic [5:0] NOP  = 6'h00;
  localparam logic [5:0] ADD  = 6'h01;
  localparam logic [5:0] ADDI = 6'h02;
  localparam logic [5:0] LDI  = 6'h03;
  localparam logic [5:0] MUL  = 6'h04;
  localparam logic [5:0] BEQ  = 6'h05;
  localparam logic [5:0] INW  = 6'h06;
  localparam logic [5:0] HALT = 6'h3F;

  localparam logic [2:0] ALU_B   = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_EXEC     = 3'd1,
    S_MUL_WAIT = 3'd2,
    S_IN_WAIT  = 3'd3,
    S_HALT     = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic       ir_load;
    logic       pc_incr;
    logic       pc_load;
    logic       imm;
    logic       w1;
    logic [2:0] alu;
    logic       mul_start;
    logic       mul_sel;
    logic       in_sel;
    logic       in_ready;
    logic       halted;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/pico_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : pico_seq_ctrl_if
// Brief   : Sequencer <-> instruction register / datapath signal bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface pico_seq_ctrl_if #(
  parameter int ALU_W = 3
);
  logic [5:0]       opcode;
  logic             zflag;
  logic             in_valid;
  logic             in_ready;
  logic             ir_load;
  logic             PCincr;
  logic             PCload;
  logic             imm;
  logic             w1;
  logic [ALU_W-1:0] ALUfunc;
  logic             mul_start;
  logic             mul_sel;
  logic             in_sel;
  logic             halted;

  // master = sequencer, slave = instruction register / datapath side
  modport master (
    input  opcode, zflag, in_valid,
    output in_ready, ir_load, PCincr, PCload, imm, w1, ALUfunc,
           mul_start, mul_sel, in_sel, halted
  );

  modport slave (
    output opcode, zflag, in_valid,
    input  in_ready, ir_load, PCincr, PCload, imm, w1, ALUfunc,
           mul_start, mul_sel, in_sel, halted
  );
endinterface
`default_nettype wire

// File: rtl/pico_seq_ctrl_mul_timer.sv
`default_nettype none
// ============================================================================
// Module  : pico_mul_timer
// Brief   : Loadable 4-bit down-counter timing the multiplier latency.
// Revision: 1.0 - initial release
// ============================================================================
module pico_mul_timer (
  input  wire logic       clk,
  input  wire logic       nReset,
  input  wire logic       load_i,
  input  wire logic [3:0] load_val_i,
  input  wire logic       dec_i,
  output logic            done_o
);
  import pico_pkg::*;

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == 4'd0);
endmodule
`default_nettype wire

// File: rtl/pico_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pico_seq_ctrl
// Brief   : Multi-cycle control sequencer turning opcodes into timed strobes.
// Revision: 1.0 - initial release
// ============================================================================
module pico_seq_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int ALU_W      = 3
) (
  input  wire logic        clk,
  input  wire logic        nReset,
  pico_seq_ctrl_if.master  bus
);
  import pico_pkg::*;

  seq_state_t state_q;
  seq_state_t state_d;
  ctrl_t      ctrl_w;
  ctrl_t      ctrl_out_w;
  logic       mul_load_w;
  logic       mul_dec_w;
  logic       mul_done_w;

  pico_mul_timer u_mul_timer (
    .clk        (clk),
    .nReset     (nReset),
    .load_i     (mul_load_w),
    .load_val_i (4'(MUL_CYCLES - 1)),
    .dec_i      (mul_dec_w),
    .done_o     (mul_done_w)
  );

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ctrl_w     = '0;
    mul_load_w = 1'b0;
    mul_dec_w  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ctrl_w.ir_load = 1'b1;
        state_d        = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (bus.opcode)
          ADD, ADDI: begin
            ctrl_w.w1      = 1'b1;
            ctrl_w.alu     = ALU_ADD;
            ctrl_w.pc_incr = 1'b1;
            ctrl_w.imm     = (bus.opcode == ADDI);
          end
          LDI: begin
            ctrl_w.w1      = 1'b1;
            ctrl_w.imm     = 1'b1;
            ctrl_w.alu     = ALU_B;
            ctrl_w.pc_incr = 1'b1;
          end
          MUL: begin
            // With MUL_CYCLES==1 the timer loads 0, so MUL_WAIT completes at once.
            ctrl_w.mul_start = 1'b1;
            mul_load_w       = 1'b1;
            state_d          = S_MUL_WAIT;
          end
          BEQ: begin
            ctrl_w.pc_load = bus.zflag;
            ctrl_w.pc_incr = !bus.zflag;
          end
          INW:     state_d = S_IN_WAIT;
          HALT:    state_d = S_HALT;
          default: ctrl_w.pc_incr = 1'b1;
        endcase
      end
      S_MUL_WAIT: begin
        if (mul_done_w) begin
          ctrl_w.w1      = 1'b1;
          ctrl_w.mul_sel = 1'b1;
          ctrl_w.pc_incr = 1'b1;
          state_d        = S_FETCH;
        end else begin
          mul_dec_w = 1'b1;
        end
      end
      S_IN_WAIT: begin
        ctrl_w.in_ready = 1'b1;
        if (bus.in_valid) begin
          ctrl_w.w1      = 1'b1;
          ctrl_w.in_sel  = 1'b1;
          ctrl_w.pc_incr = 1'b1;
          state_d        = S_FETCH;
        end
      end
      S_HALT:  ctrl_w.halted = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  // Outputs are forced low for the whole time reset is held, even though
  // the state register already sits at FETCH.
  assign ctrl_out_w = nReset ? ctrl_w : '0;

  assign bus.ir_load   = ctrl_out_w.ir_load;
  assign bus.PCincr    = ctrl_out_w.pc_incr;
  assign bus.PCload    = ctrl_out_w.pc_load;
  assign bus.imm       = ctrl_out_w.imm;
  assign bus.w1        = ctrl_out_w.w1;
  assign bus.ALUfunc   = ALU_W'(ctrl_out_w.alu);
  assign bus.mul_start = ctrl_out_w.mul_start;
  assign bus.mul_sel   = ctrl_out_w.mul_sel;
  assign bus.in_sel    = ctrl_out_w.in_sel;
  assign bus.in_ready  = ctrl_out_w.in_ready;
  assign bus.halted    = ctrl_out_w.halted;
endmodule
`default_nettype wire

// File: tb/tb_pico_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pico_seq_ctrl
// Brief   : Scoreboard bench for pico_seq_ctrl with an instruction-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pico_seq_ctrl;
  import pico_pkg::*;

  localparam int MUL_CYCLES = 4;

  logic clk;
  logic nReset;
  int   total;
  int   bad;

  logic [14:0] expq[$];
  string       tagq[$];

  pico_seq_ctrl_if #(.ALU_W(3)) bus ();

  pico_seq_ctrl #(.MUL_CYCLES(MUL_CYCLES), .ALU_W(3)) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ir_load, PCincr, PCload, imm, w1, ALUfunc[2:0], mul_start, mul_sel, in_sel, in_ready, halted}
  function automatic logic [14:0] ev(input logic irl, input logic pci, input logic pcl,
                                     input logic im, input logic w, input logic [2:0] alu,
                                     input logic ms, input logic msel, input logic isel,
                                     input logic rdy, input logic h);
    return {irl, pci, pcl, im, w, alu, ms, msel, isel, rdy, h};
  endfunction

  // One clock cycle of stimulus; the expected outputs for that cycle go to the scoreboard.
  task automatic cyc(input logic [5:0] op, input logic z, input logic iv, input logic rn,
                     input logic [14:0] e, input string tag);
    @(posedge clk);
    #1;
    bus.opcode   = op;
    bus.zflag    = z;
    bus.in_valid = iv;
    nReset       = rn;
    expq.push_back(e);
    tagq.push_back(tag);
  endtask

  // Whole-instruction reference: fetch cycle, then the opcode's cycle sequence.
  task automatic run_instr(input logic [5:0] op, input logic z, input int nwait);
    logic [14:0] zero;
    zero = '0;
    cyc(op, 1'($urandom), 1'($urandom), 1'b1, ev(1,0,0,0,0,ALU_B,0,0,0,0,0), "fetch");
    case (op)
      ADD:  cyc(op, z, 1'($urandom), 1'b1, ev(0,1,0,0,1,ALU_ADD,0,0,0,0,0), "exec_add");
      ADDI: cyc(op, z, 1'($urandom), 1'b1, ev(0,1,0,1,1,ALU_ADD,0,0,0,0,0), "exec_addi");
      LDI:  cyc(op, z, 1'($urandom), 1'b1, ev(0,1,0,1,1,ALU_B,0,0,0,0,0), "exec_ldi");
      BEQ:  cyc(op, z, 1'($urandom), 1'b1, ev(0,!z,z,0,0,ALU_B,0,0,0,0,0), "exec_beq");
      MUL: begin
        cyc(op, z, 1'($urandom), 1'b1, ev(0,0,0,0,0,ALU_B,1,0,0,0,0), "exec_mul");
        for (int k = 1; k < MUL_CYCLES; k++)
          cyc(op, 1'($urandom), 1'($urandom), 1'b1, zero, "mul_wait");
        cyc(op, 1'($urandom), 1'($urandom), 1'b1, ev(0,1,0,0,1,ALU_B,0,1,0,0,0), "mul_done");
      end
      INW: begin
        cyc(op, z, 1'($urandom), 1'b1, zero, "exec_inw");
        for (int k = 0; k < nwait; k++)
          cyc(op, 1'($urandom), 1'b0, 1'b1, ev(0,0,0,0,0,ALU_B,0,0,0,1,0), "in_wait");
        cyc(op, 1'($urandom), 1'b1, 1'b1, ev(0,1,0,0,1,ALU_B,0,0,1,1,0), "in_accept");
      end
      HALT: cyc(op, z, 1'($urandom), 1'b1, zero, "exec_halt");
      default: cyc(op, z, 1'($urandom), 1'b1, ev(0,1,0,0,0,ALU_B,0,0,0,0,0), "exec_nop");
    endcase
  endtask

  // Monitor: compares the DUT against the oldest expectation every cycle.
  initial begin
    logic [14:0] e;
    logic [14:0] act;
    string       t;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e   = expq.pop_front();
        t   = tagq.pop_front();
        act = {bus.ir_load, bus.PCincr, bus.PCload, bus.imm, bus.w1, bus.ALUfunc,
               bus.mul_start, bus.mul_sel, bus.in_sel, bus.in_ready, bus.halted};
        total++;
        if (act !== e) begin
          bad++;
          $display("FAIL %s t=%0t got=%b want=%b", t, $time, act, e);
        end
      end
    end
  end

  initial begin
    logic [14:0] zero;
    logic [5:0]  op;
    int          r;
    zero         = '0;
    total        = 0;
    bad          = 0;
    nReset       = 1'b0;
    bus.opcode   = NOP;
    bus.zflag    = 1'b0;
    bus.in_valid = 1'b0;

    cyc(LDI, 1'b0, 1'b1, 1'b0, zero, "reset");
    cyc(LDI, 1'b0, 1'b1, 1'b0, zero, "reset");

    run_instr(LDI, 1'b0, 0);
    run_instr(LDI, 1'b1, 0);
    run_instr(MUL, 1'b0, 0);
    run_instr(BEQ, 1'b1, 0);
    run_instr(BEQ, 1'b0, 0);
    run_instr(INW, 1'b0, 5);
    run_instr(6'h2A, 1'b1, 0);
    run_instr(ADDI, 1'b0, 0);

    // Reset in the middle of MUL_WAIT, then a complete fresh MUL.
    cyc(MUL, 1'b0, 1'b0, 1'b1, ev(1,0,0,0,0,ALU_B,0,0,0,0,0), "fetch");
    cyc(MUL, 1'b0, 1'b0, 1'b1, ev(0,0,0,0,0,ALU_B,1,0,0,0,0), "exec_mul");
    cyc(MUL, 1'b0, 1'b1, 1'b1, zero, "mul_wait");
    cyc(MUL, 1'b0, 1'b1, 1'b0, zero, "reset_mid_mul");
    cyc(MUL, 1'b0, 1'b1, 1'b0, zero, "reset_mid_mul");
    run_instr(MUL, 1'b0, 0);

    // Reset while waiting for an input sample.
    cyc(INW, 1'b0, 1'b0, 1'b1, ev(1,0,0,0,0,ALU_B,0,0,0,0,0), "fetch");
    cyc(INW, 1'b0, 1'b0, 1'b1, zero, "exec_inw");
    cyc(INW, 1'b0, 1'b0, 1'b1, ev(0,0,0,0,0,ALU_B,0,0,0,1,0), "in_wait");
    cyc(INW, 1'b0, 1'b1, 1'b0, zero, "reset_mid_inw");

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 6)      op = 6'(r);
      else if (r == 9) op = ADD;
      else             op = 6'($urandom_range(7, 62));
      run_instr(op, 1'($urandom), $urandom_range(0, 4));
    end

    run_instr(HALT, 1'b0, 0);
    for (int i = 0; i < 6; i++)
      cyc(ADD, 1'($urandom), 1'($urandom), 1'b1, ev(0,0,0,0,0,ALU_B,0,0,0,0,1), "halted");

    repeat (2) @(posedge clk);
    for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
    if (expq.size() > 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
